// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
// A signed overflow on add/sub squashes the next incoming instruction.

module alu #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf
);
  logic [N:0] sum;

  // Subtraction is a + ~b + 1, so c_out=1 means "no borrow".
  always_comb begin
    sum   = '0;
    s     = '0;
    c_out = 1'b0;
    ovf   = 1'b0;
    case (op)
      3'd0: begin
        sum   = {1'b0, a} + {1'b0, b};
        s     = sum[N-1:0];
        c_out = sum[N];
        ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      3'd1: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        s     = sum[N-1:0];
        c_out = sum[N];
        ovf   = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
      end
      3'd2: s = a & b;
      3'd3: s = a | b;
      3'd4: s = a ^ b;
      3'd5: s = (a > b) ? {{(N-1){1'b0}}, 1'b1} : '0;
      3'd6: s = {a[N-2:0], 1'b0};
      default: s = {1'b0, a[N-1:1]};
    endcase
  end
endmodule

// state  | meaning
// RUN    | normal issue into EX/MEM
// SQUASH | previous add/sub overflowed; load incoming instruction as a bubble
module ex_mem_stage #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [2:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_rs_val,
  input  logic [15:0]       id_rt_val,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_wr_en,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [15:0]       wb_val,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [15:0]       mem_result,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_wr_en,
  output logic              mem_cout,
  output logic              ovf_exc
);
  localparam int N = 16;

  typedef enum logic {RUN, SQUASH} state_t;
  state_t state;

  logic [N-1:0] op_a, fwd_b, op_b, alu_s;
  logic         alu_cout, alu_ovf, ovf_hit;

  // EX/MEM outranks WB; register 0 is never forwarded.
  always_comb begin
    op_a = id_rs_val;
    if (mem_valid && mem_wr_en && (mem_rd == id_rs) && (id_rs != '0))
      op_a = mem_result;
    else if (wb_wr_en && (wb_rd == id_rs) && (id_rs != '0))
      op_a = wb_val;
  end

  always_comb begin
    fwd_b = id_rt_val;
    if (mem_valid && mem_wr_en && (mem_rd == id_rt) && (id_rt != '0))
      fwd_b = mem_result;
    else if (wb_wr_en && (wb_rd == id_rt) && (id_rt != '0))
      fwd_b = wb_val;
  end

  assign op_b = id_use_imm ? id_imm : fwd_b;

  alu #(.N(N)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .op    (id_op),
    .s     (alu_s),
    .c_out (alu_cout),
    .ovf   (alu_ovf)
  );

  assign ovf_hit = id_valid && ((id_op == 3'd0) || (id_op == 3'd1)) && alu_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_rd     <= '0;
      mem_wr_en  <= 1'b0;
      mem_cout   <= 1'b0;
      ovf_exc    <= 1'b0;
    end else if (flush) begin
      state      <= RUN;
      mem_valid  <= 1'b0;
      mem_result <= alu_s;
      mem_rd     <= id_rd;
      mem_wr_en  <= 1'b0;
      mem_cout   <= alu_cout;
      ovf_exc    <= 1'b0;
    end else if (stall) begin
      ovf_exc    <= 1'b0;
    end else begin
      mem_result <= alu_s;
      mem_rd     <= id_rd;
      mem_cout   <= alu_cout;
      case (state)
        SQUASH: begin
          state     <= RUN;
          mem_valid <= 1'b0;
          mem_wr_en <= 1'b0;
          ovf_exc   <= 1'b0;
        end
        default: begin
          state     <= ovf_hit ? SQUASH : RUN;
          mem_valid <= id_valid;
          mem_wr_en <= id_valid && id_wr_en && !ovf_hit;
          ovf_exc   <= ovf_hit;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector table for ex_mem_stage plus hand sequences for stall,
// flush and asynchronous reset during the squash cycle.
module tb_ex_mem_stage;
  logic        clk, rst_n;
  logic        id_valid, id_use_imm, id_wr_en, wb_wr_en, stall, flush;
  logic [2:0]  id_op, id_rs, id_rt, id_rd, wb_rd;
  logic [15:0] id_rs_val, id_rt_val, id_imm, wb_val;
  logic        mem_valid, mem_wr_en, mem_cout, ovf_exc;
  logic [15:0] mem_result;
  logic [2:0]  mem_rd;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_wr_en(id_wr_en),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_val(wb_val),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_wr_en(mem_wr_en), .mem_cout(mem_cout), .ovf_exc(ovf_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  op, rs, rt, rd;
    logic [15:0] rs_val, rt_val, imm;
    logic        use_imm, wr_en, wb_wr;
    logic [2:0]  wb_rd;
    logic [15:0] wb_val;
    logic        flush, chk_data;
    logic        e_valid;
    logic [15:0] e_result;
    logic [2:0]  e_rd;
    logic        e_wr, e_cout, e_ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] a, input logic [15:0] b);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = a; id_rt_val = b; id_imm = 16'h0; id_use_imm = 1'b0; id_wr_en = 1'b1;
    wb_wr_en = 1'b0; wb_rd = 3'd0; wb_val = 16'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid op rs rt rd rs_val rt_val imm use_imm wr | wb_wr wb_rd wb_val | flush chk | expected
    vecs[0]  = '{1'b1,3'd0,3'd2,3'd3,3'd1,16'h0005,16'h0007,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h000C,3'd1,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b1,3'd0,3'd1,3'd1,3'd4,16'h0000,16'h0000,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0018,3'd4,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1,3'd0,3'd0,3'd0,3'd2,16'h0200,16'h0000,16'h0000,1'b0,1'b1, 1'b1,3'd0,16'hFFFF, 1'b0,1'b1, 1'b1,16'h0200,3'd2,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b1,3'd0,3'd2,3'd2,3'd3,16'h0011,16'h0011,16'h0000,1'b0,1'b1, 1'b1,3'd2,16'h0100, 1'b0,1'b1, 1'b1,16'h0400,3'd3,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b1,3'd1,3'd5,3'd3,3'd6,16'h0000,16'h0000,16'h0000,1'b0,1'b1, 1'b1,3'd5,16'h0100, 1'b0,1'b1, 1'b1,16'hFD00,3'd6,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b1,3'd2,3'd7,3'd7,3'd0,16'hF0F0,16'h0FF0,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h00F0,3'd0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b1,3'd3,3'd0,3'd0,3'd1,16'h1200,16'h0034,16'h0000,1'b0,1'b1, 1'b1,3'd0,16'hFFFF, 1'b0,1'b1, 1'b1,16'h1234,3'd1,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b1,3'd4,3'd4,3'd1,3'd2,16'h00FF,16'h9999,16'h0F0F,1'b1,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0FF0,3'd2,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,3'd1,3'd5,3'd6,3'd3,16'h0003,16'h0005,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'hFFFE,3'd3,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b1,3'd5,3'd6,3'd0,3'd4,16'h8000,16'h0000,16'h0001,1'b1,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0001,3'd4,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,3'd7,3'd7,3'd0,3'd5,16'h8001,16'h0000,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h4000,3'd5,1'b1,1'b0,1'b0};
    vecs[11] = '{1'b1,3'd6,3'd7,3'd0,3'd5,16'h8001,16'h0000,16'h0000,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0002,3'd5,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,3'd0,3'd1,3'd2,3'd6,16'hFFFF,16'h0002,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0001,3'd6,1'b1,1'b1,1'b0};
    vecs[13] = '{1'b0,3'd0,3'd1,3'd2,3'd7,16'h0003,16'h0004,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b0,16'h0007,3'd7,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b1,3'd0,3'd1,3'd2,3'd1,16'h7FFF,16'h0001,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h8000,3'd1,1'b0,1'b0,1'b1};
    vecs[15] = '{1'b1,3'd0,3'd1,3'd2,3'd3,16'h0001,16'h0001,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b0,16'h0002,3'd3,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,3'd0,3'd1,3'd2,3'd4,16'h0002,16'h0003,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0005,3'd4,1'b1,1'b0,1'b0};
    vecs[17] = '{1'b1,3'd1,3'd1,3'd2,3'd5,16'h8000,16'h0001,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h7FFF,3'd5,1'b0,1'b1,1'b1};
    vecs[18] = '{1'b1,3'd0,3'd1,3'd2,3'd6,16'h0001,16'h0002,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b1,1'b0, 1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0};
    vecs[19] = '{1'b1,3'd0,3'd1,3'd2,3'd6,16'h0001,16'h0002,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0003,3'd6,1'b1,1'b0,1'b0};
    vecs[20] = '{1'b1,3'd6,3'd3,3'd0,3'd7,16'h4000,16'h0000,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h8000,3'd7,1'b1,1'b0,1'b0};
    vecs[21] = '{1'b1,3'd3,3'd1,3'd2,3'd1,16'h0001,16'h0002,16'h0000,1'b0,1'b1, 1'b0,3'd0,16'h0000, 1'b0,1'b1, 1'b1,16'h0003,3'd1,1'b1,1'b0,1'b0};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
    #12;
    chk("rst.valid", 16'(mem_valid), 16'h0);
    chk("rst.result", mem_result, 16'h0);
    chk("rst.rd", 16'(mem_rd), 16'h0);
    chk("rst.wr_en", 16'(mem_wr_en), 16'h0);
    chk("rst.cout", 16'(mem_cout), 16'h0);
    chk("rst.ovf_exc", 16'(ovf_exc), 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      id_valid = vecs[i].valid; id_op = vecs[i].op; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rd = vecs[i].rd; id_rs_val = vecs[i].rs_val; id_rt_val = vecs[i].rt_val;
      id_imm = vecs[i].imm; id_use_imm = vecs[i].use_imm; id_wr_en = vecs[i].wr_en;
      wb_wr_en = vecs[i].wb_wr; wb_rd = vecs[i].wb_rd; wb_val = vecs[i].wb_val;
      flush = vecs[i].flush;
      step();
      chk($sformatf("v%0d.valid", i), 16'(mem_valid), 16'(vecs[i].e_valid));
      chk($sformatf("v%0d.wr_en", i), 16'(mem_wr_en), 16'(vecs[i].e_wr));
      chk($sformatf("v%0d.ovf_exc", i), 16'(ovf_exc), 16'(vecs[i].e_ovf));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d.result", i), mem_result, vecs[i].e_result);
        chk($sformatf("v%0d.rd", i), 16'(mem_rd), 16'(vecs[i].e_rd));
        chk($sformatf("v%0d.cout", i), 16'(mem_cout), 16'(vecs[i].e_cout));
      end
    end
    flush = 1'b0;

    // Stall three cycles with changing inputs, one of them an overflowing add.
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1'b1, 3'd0, 3'd3, 3'd4, 3'd2, 16'h7FFF, 16'h0001);
        1: drive(1'b1, 3'd4, 3'd5, 3'd6, 3'd5, 16'hAAAA, 16'h5555);
        default: drive(1'b0, 3'd0, 3'd1, 3'd1, 3'd6, 16'h1111, 16'h2222);
      endcase
      step();
      chk($sformatf("stall%0d.valid", c), 16'(mem_valid), 16'h1);
      chk($sformatf("stall%0d.result", c), mem_result, 16'h0003);
      chk($sformatf("stall%0d.rd", c), 16'(mem_rd), 16'h1);
      chk($sformatf("stall%0d.wr_en", c), 16'(mem_wr_en), 16'h1);
      chk($sformatf("stall%0d.ovf_exc", c), 16'(ovf_exc), 16'h0);
    end
    stall = 1'b0;
    drive(1'b1, 3'd0, 3'd1, 3'd1, 3'd2, 16'h0000, 16'h0000);
    step();
    chk("post_stall.fwd_result", mem_result, 16'h0006);
    chk("post_stall.valid", 16'(mem_valid), 16'h1);
    chk("post_stall.ovf_exc", 16'(ovf_exc), 16'h0);

    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 3'd0, 3'd3, 3'd4, 3'd2, 16'h0001, 16'h0001);
    step();
    chk("stall_flush.valid", 16'(mem_valid), 16'h0);
    chk("stall_flush.wr_en", 16'(mem_wr_en), 16'h0);
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd0, 3'd2, 3'd2, 3'd3, 16'h0010, 16'h0020);
    step();
    chk("after_flush.valid", 16'(mem_valid), 16'h1);
    chk("after_flush.result", mem_result, 16'h0030);

    // Overflow puts the stage in SQUASH, then reset arrives between edges.
    drive(1'b1, 3'd0, 3'd1, 3'd2, 3'd4, 16'h7FFF, 16'h0001);
    step();
    chk("sq.ovf_exc", 16'(ovf_exc), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 16'(mem_valid), 16'h0);
    chk("async_rst.result", mem_result, 16'h0);
    chk("async_rst.rd", 16'(mem_rd), 16'h0);
    chk("async_rst.wr_en", 16'(mem_wr_en), 16'h0);
    chk("async_rst.ovf_exc", 16'(ovf_exc), 16'h0);
    #1 rst_n = 1'b1;
    drive(1'b1, 3'd0, 3'd1, 3'd2, 3'd1, 16'h0001, 16'h0001);
    step();
    chk("post_rst.valid", 16'(mem_valid), 16'h1);
    chk("post_rst.result", mem_result, 16'h0002);
    chk("post_rst.wr_en", 16'(mem_wr_en), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: REG_AW, default 3, register-address width (8 GPRs; R0 hardwired zero).
REQ-002 The block SHALL have the following ports, with the datapath width fixed at 16 bits (`N):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID/EX holds a live instruction.
- id_op  in  3  ALU opcode.
- id_rs, id_rt, id_rd  in  REG_AW  source/dest register numbers.
- id_rs_val, id_rt_val  in  16  register-file read values.
- id_imm  in  16  sign-extended immediate.
- id_use_imm  in  1  operand B = id_imm instead of forwarded rt.
- id_wr_en  in  1  instruction writes id_rd.
- wb_wr_en, wb_rd, wb_val  in  1/REG_AW/16  writeback-stage forward source.
- stall  in  1  hold stage contents.
- flush  in  1  kill stage contents.
- mem_valid  out  1  EX/MEM holds a live result.
- mem_result  out  16  registered ALU result.
- mem_rd  out  REG_AW  registered destination.
- mem_wr_en  out  1  registered write enable (qualified).
- mem_cout  out  1  registered carry-out.
- ovf_exc  out  1  one-cycle overflow-exception pulse.

Function
REQ-003 ALU opcodes SHALL be: 0 a+b, 1 a-b, 2 a&b, 3 a|b, 4 a^b, 5 (a>b unsigned ? 1 : 0), 6 a<<1, 7 a>>1 (logical); the block SHALL instantiate the team ALU module for this.
REQ-004 Operand A SHALL be forwarded: if mem_valid & mem_wr_en & mem_rd==id_rs & id_rs!=0 -> mem_result; else if wb_wr_en & wb_rd==id_rs & id_rs!=0 -> wb_val; else id_rs_val.
REQ-005 Operand B SHALL be id_imm when id_use_imm=1; otherwise forwarded as REQ-004 using id_rt/id_rt_val.
REQ-006 EX/MEM forward SHALL have priority over WB forward; R0 SHALL never be forwarded.
REQ-007 Latency: result of an instruction accepted at edge k SHALL appear on mem_* after edge k (one cycle).
REQ-008 FSM states RUN and SQUASH; reset state RUN.
REQ-009 In RUN, no stall/flush: mem_valid<=id_valid; mem_result<=ALU s; mem_rd<=id_rd; mem_cout<=ALU cOut; mem_wr_en<=id_valid & id_wr_en & ~ovf_hit.
REQ-010 ovf_hit SHALL be id_valid & (id_op==0 | id_op==1) & ALU ovf; on ovf_hit ovf_exc SHALL pulse high for exactly the following cycle and FSM SHALL go to SQUASH.
REQ-011 In SQUASH (one cycle) the incoming instruction SHALL be loaded with mem_valid=0, mem_wr_en=0, no ovf_exc; FSM returns to RUN.
REQ-012 stall=1 (flush=0): all mem_* registers and FSM state SHALL hold; ovf_exc SHALL be 0; forwarding from mem_* remains active.
REQ-013 flush=1: mem_valid<=0, mem_wr_en<=0, ovf_exc<=0, FSM<=RUN, regardless of stall; flush wins over stall.
REQ-014 mem_result/mem_rd/mem_cout for an invalid slot are don't-care but SHALL be loaded deterministically per REQ-009.
REQ-015 Overflow on ops 2-7 SHALL be ignored.

Reset
REQ-016 rst_n=0 SHALL immediately (asynchronously) force mem_valid=0, mem_result=0, mem_rd=0, mem_wr_en=0, mem_cout=0, ovf_exc=0, FSM=RUN.
REQ-017 Reset mid-stall or in SQUASH SHALL yield the same state as REQ-016; first edge after release behaves per RUN.

Verification
REQ-018 Back-to-back ADD: r1=r2+r3 (5+7) then r4=r1+r1 with stale id_rs_val=0 -> second mem_result=24 (EX/MEM forward).
REQ-019 Dual forward: wb_rd=2,wb_val=0x0100 and mem_rd=2,mem_result=0x0200, op=0, rs=rt=2 -> mem_result=0x0400; rd=0 source with forwarding enabled -> raw id_*_val used.
REQ-020 Overflow: op=0, a=0x7FFF, b=0x0001 -> mem_result=0x8000, mem_wr_en=0, ovf_exc=1 one cycle; next valid instruction -> mem_valid=0; following one -> normal.
REQ-021 SUB/GT/shift: a=3,b=5 op=1 -> 0xFFFE, mem_cout=0, no exc; op=5 a=0x8000,b=1 -> 1; op=7 a=0x8001 -> 0x4000.
REQ-022 Stall 3 cycles with changing inputs -> mem_* unchanged; stall+flush same cycle -> mem_valid=0.
REQ-023 Assert rst_n=0 between edges during SQUASH -> outputs zero without a clock edge; after release ADD 1+1 -> 2.
